// File: rtl/trees_pkg.sv
// Shared constants, derived widths and sequencer state encoding for the
// trees_ping_pong burst sequencer.
package trees_pkg;

    localparam int unsigned N_FEATURE      = 32;
    localparam int unsigned HALF_FEATURE   = N_FEATURE / 2;
    localparam int unsigned MAX_BURST      = 54;
    localparam int unsigned MAX_BURST_BITS = $clog2(MAX_BURST);
    localparam int unsigned WCNT_BITS      = $clog2(MAX_BURST * HALF_FEATURE) + 1;
    localparam int unsigned BYTE_IDX_BITS  = MAX_BURST_BITS + 3;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LOAD    = 4'd1,
        S_START   = 4'd2,
        S_GUARD   = 4'd3,
        S_WAIT    = 4'd4,
        S_RD_ADDR = 4'd5,
        S_RD_CAP  = 4'd6,
        S_EMIT    = 4'd7,
        S_NEXT    = 4'd8,
        S_FIN     = 4'd9
    } seq_state_t;

    function automatic logic [MAX_BURST_BITS-1:0] burst_of(input logic [31:0] remaining);
        if (remaining > 32'(MAX_BURST))
            return MAX_BURST_BITS'(MAX_BURST);
        else
            return remaining[MAX_BURST_BITS-1:0];
    endfunction

endpackage

// File: rtl/trees_burst_sequencer_if.sv
// Host/DMA, accelerator and prediction-stream signals of the burst sequencer.
interface trees_burst_sequencer_if;
    import trees_pkg::*;

    logic                      cfg_go;
    logic [31:0]               cfg_n_samples;
    logic                      busy;
    logic                      all_done;

    logic                      feat_valid;
    logic                      feat_ready;
    logic [63:0]               feat_data;

    logic                      acc_load_features;
    logic [31:0]               acc_feature_addr;
    logic [63:0]               acc_features2;
    logic [MAX_BURST_BITS-1:0] acc_burst_len;
    logic                      acc_start;
    logic                      acc_done;
    logic [MAX_BURST_BITS-1:0] acc_prediction_addr;
    logic [63:0]               acc_prediction;

    logic                      pred_valid;
    logic                      pred_ready;
    logic [7:0]                pred_data;
    logic                      pred_last;

    // Sequencer side.
    modport slave (
        input  cfg_go, cfg_n_samples, feat_valid, feat_data,
               acc_done, acc_prediction, pred_ready,
        output busy, all_done, feat_ready,
               acc_load_features, acc_feature_addr, acc_features2,
               acc_burst_len, acc_start, acc_prediction_addr,
               pred_valid, pred_data, pred_last
    );

    // Host, accelerator and prediction sink side.
    modport master (
        output cfg_go, cfg_n_samples, feat_valid, feat_data,
               acc_done, acc_prediction, pred_ready,
        input  busy, all_done, feat_ready,
               acc_load_features, acc_feature_addr, acc_features2,
               acc_burst_len, acc_start, acc_prediction_addr,
               pred_valid, pred_data, pred_last
    );

endinterface

// File: rtl/pred_unpacker.sv
// Holds one captured 64-bit prediction word and streams its valid bytes,
// low byte first, over a valid/ready handshake.
module pred_unpacker (
    input  logic        clk,
    input  logic        rst,
    input  logic        capture,
    input  logic [63:0] word,
    input  logic [3:0]  count,
    input  logic        final_word,
    input  logic        emit,
    input  logic        ready,
    output logic        valid,
    output logic [7:0]  data,
    output logic        last,
    output logic        word_done
);

    logic [63:0] shreg;
    logic [3:0]  nleft;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            nleft <= '0;
        end else if (capture) begin
            shreg <= word;
            nleft <= count;
        end else if (valid && ready) begin
            shreg <= shreg >> 8;
            nleft <= nleft - 4'd1;
        end
    end

    // Outputs depend only on registered state, so they hold under back-pressure.
    always_comb begin
        valid     = emit && (nleft != 4'd0);
        data      = valid ? shreg[7:0] : '0;
        last      = valid && final_word && (nleft == 4'd1);
        word_done = valid && ready && (nleft == 4'd1);
    end

endmodule

// File: rtl/trees_burst_sequencer.sv
// Splits a run of samples into accelerator bursts: loads features, starts the
// accelerator, waits for done and streams the packed predictions out as bytes.
module trees_burst_sequencer
    import trees_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    trees_burst_sequencer_if.slave bus
);

    seq_state_t                state;
    logic [31:0]               remaining;
    logic [MAX_BURST_BITS-1:0] blen;
    logic [MAX_BURST_BITS-1:0] widx;
    logic [WCNT_BITS-1:0]      wcnt;
    logic                      guard_cnt;

    logic                      load_beat;
    logic                      last_beat;
    logic [WCNT_BITS-1:0]      words_needed;
    logic [BYTE_IDX_BITS-1:0]  next_bytes;
    logic [BYTE_IDX_BITS-1:0]  rem_bytes;
    logic                      more_words;
    logic [3:0]                word_bytes;
    logic                      final_word;
    logic                      in_burst;
    logic                      word_done;

    always_comb begin
        load_beat    = (state == S_LOAD) && bus.feat_valid;
        words_needed = WCNT_BITS'(blen) * WCNT_BITS'(HALF_FEATURE);
        last_beat    = load_beat && (wcnt == words_needed - WCNT_BITS'(1));
        next_bytes   = {widx + MAX_BURST_BITS'(1), 3'b000};
        rem_bytes    = {3'b000, blen} - {widx, 3'b000};
        more_words   = next_bytes < {3'b000, blen};
        word_bytes   = (rem_bytes >= BYTE_IDX_BITS'(8)) ? 4'd8 : rem_bytes[3:0];
        // Only the last word of the last burst carries the run's final byte.
        final_word   = (remaining == 32'(blen)) && !more_words;
        in_burst     = (state == S_START) || (state == S_GUARD) || (state == S_WAIT) ||
                       (state == S_RD_ADDR) || (state == S_RD_CAP) || (state == S_EMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            remaining <= '0;
            blen      <= '0;
            widx      <= '0;
            wcnt      <= '0;
            guard_cnt <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cfg_go) begin
                        remaining <= bus.cfg_n_samples;
                        wcnt      <= '0;
                        widx      <= '0;
                        if (bus.cfg_n_samples == 32'd0) begin
                            state <= S_FIN;
                        end else begin
                            blen  <= burst_of(bus.cfg_n_samples);
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (load_beat) begin
                        wcnt <= wcnt + WCNT_BITS'(1);
                        if (last_beat)
                            state <= S_START;
                    end
                end
                S_START: begin
                    guard_cnt <= 1'b0;
                    state     <= S_GUARD;
                end
                // A done level left high by the previous burst is masked here.
                S_GUARD: begin
                    guard_cnt <= 1'b1;
                    if (guard_cnt)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.acc_done)
                        state <= S_RD_ADDR;
                end
                S_RD_ADDR: state <= S_RD_CAP;
                S_RD_CAP:  state <= S_EMIT;
                S_EMIT: begin
                    if (word_done) begin
                        widx  <= widx + MAX_BURST_BITS'(1);
                        state <= more_words ? S_RD_ADDR : S_NEXT;
                    end
                end
                S_NEXT: begin
                    remaining <= remaining - 32'(blen);
                    if (remaining != 32'(blen)) begin
                        blen  <= burst_of(remaining - 32'(blen));
                        wcnt  <= '0;
                        widx  <= '0;
                        state <= S_LOAD;
                    end else begin
                        state <= S_FIN;
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy                = (state != S_IDLE);
        bus.all_done            = (state == S_FIN);
        bus.feat_ready          = (state == S_LOAD);
        bus.acc_load_features   = load_beat;
        bus.acc_feature_addr    = load_beat ? 32'(wcnt) : '0;
        bus.acc_features2       = load_beat ? bus.feat_data : '0;
        bus.acc_start           = (state == S_START);
        bus.acc_burst_len       = in_burst ? blen : '0;
        bus.acc_prediction_addr = widx;
    end

    pred_unpacker unpack (
        .clk        (clk),
        .rst        (rst),
        .capture    (state == S_RD_CAP),
        .word       (bus.acc_prediction),
        .count      (word_bytes),
        .final_word (final_word),
        .emit       (state == S_EMIT),
        .ready      (bus.pred_ready),
        .valid      (bus.pred_valid),
        .data       (bus.pred_data),
        .last       (bus.pred_last),
        .word_done  (word_done)
    );

endmodule

// File: tb/tb_trees_burst_sequencer.sv
// Directed bench for trees_burst_sequencer with a behavioural accelerator.
module tb_trees_burst_sequencer;
    import trees_pkg::*;

    localparam int unsigned FMEM_WORDS = MAX_BURST * HALF_FEATURE;
    localparam int unsigned ACC_LAT    = 20;
    localparam int unsigned NONE       = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    trees_burst_sequencer_if bus ();

    trees_burst_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] feat_word(input int unsigned s, input int unsigned w);
        logic [31:0] sv;
        logic [31:0] a;
        sv = s;
        a  = sv * 32'd2654435761 + 32'(w) * 32'd40503;
        return {a, sv[15:0], 8'(w), 8'(sv + 32'(w) * 32'd7)};
    endfunction

    function automatic logic [7:0] pstep(input logic [7:0] acc, input logic [63:0] wd);
        return ((acc * 8'd3) + wd[7:0] + wd[47:40]) ^ wd[35:28];
    endfunction

    function automatic logic [7:0] golden(input int unsigned s);
        logic [7:0] acc;
        acc = '0;
        for (int unsigned w = 0; w < HALF_FEATURE; w++)
            acc = pstep(acc, feat_word(s, w));
        return acc & 8'h1f;
    endfunction

    // Accelerator model: feature RAM, predictions computed at done, 1-cycle read.
    logic [63:0]               fmem [FMEM_WORDS];
    logic [63:0]               pmem [8];
    logic                      done_q       = 1'b1;
    logic                      drop_pending = 1'b0;
    int unsigned               done_cnt     = 0;
    logic [MAX_BURST_BITS-1:0] model_blen   = '0;
    logic [63:0]               prd_q        = '0;

    assign bus.acc_done       = done_q;
    assign bus.acc_prediction = prd_q;

    function automatic logic [63:0] model_word(input int unsigned k, input int unsigned bl);
        logic [63:0] r;
        logic [7:0]  acc;
        r = '0;
        for (int unsigned j = 0; j < 8; j++) begin
            if (8 * k + j < bl) begin
                acc = '0;
                for (int unsigned w = 0; w < HALF_FEATURE; w++)
                    acc = pstep(acc, fmem[(8 * k + j) * HALF_FEATURE + w]);
                r[8 * j +: 8] = acc & 8'h1f;
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (bus.acc_load_features && bus.acc_feature_addr < 32'(FMEM_WORDS))
            fmem[bus.acc_feature_addr] <= bus.acc_features2;
        prd_q <= pmem[bus.acc_prediction_addr[2:0]];
        if (bus.acc_start) begin
            model_blen   <= bus.acc_burst_len;
            drop_pending <= 1'b1;
            done_cnt     <= ACC_LAT;
        end else begin
            // Done stays high one cycle past start, like a slow level clear.
            if (drop_pending) begin
                done_q       <= 1'b0;
                drop_pending <= 1'b0;
            end
            if (done_cnt != 0) begin
                done_cnt <= done_cnt - 1;
                if (done_cnt == 1) begin
                    for (int unsigned k = 0; k < 8; k++)
                        pmem[k] <= model_word(k, model_blen);
                    done_q <= 1'b1;
                end
            end
        end
    end

    // Bus monitor: write addressing, start/load exclusion, burst lengths, done pulses.
    int unsigned               wr_exp      = 0;
    int unsigned               start_count = 0;
    int unsigned               ready_seen  = 0;
    int unsigned               done_pulses = 0;
    logic [MAX_BURST_BITS-1:0] blq [$];

    always @(negedge clk) begin
        if (rst) begin
            wr_exp = 0;
        end else begin
            if (bus.feat_ready)
                ready_seen++;
            if (bus.acc_load_features) begin
                check("wr_addr", 64'(bus.acc_feature_addr), 64'(wr_exp));
                wr_exp++;
            end
            if (bus.acc_start) begin
                check("start_vs_load", 64'(bus.acc_load_features), 64'd0);
                check("beats_per_burst", 64'(wr_exp), 64'(bus.acc_burst_len) * 64'(HALF_FEATURE));
                blq.push_back(bus.acc_burst_len);
                start_count++;
                wr_exp = 0;
            end
            if (bus.all_done)
                done_pulses++;
        end
    end

    task automatic check_quiet(input string prefix);
        check({prefix, "_ctrl"},
              64'({bus.busy, bus.all_done, bus.feat_ready, bus.acc_load_features,
                   bus.acc_start, bus.pred_valid, bus.pred_last}), 64'd0);
        check({prefix, "_feat_addr"}, 64'(bus.acc_feature_addr), 64'd0);
        check({prefix, "_feat_data"}, bus.acc_features2, 64'd0);
        check({prefix, "_len_paddr_pdata"},
              64'({bus.acc_burst_len, bus.acc_prediction_addr, bus.pred_data}), 64'd0);
    endtask

    task automatic feed(input int unsigned base, input int unsigned nsamp,
                        input bit stall, input int unsigned go_at);
        bit          got;
        int unsigned t;
        for (int unsigned s = 0; s < nsamp; s++) begin
            for (int unsigned w = 0; w < HALF_FEATURE; w++) begin
                if (stall && $urandom_range(3) == 0) begin
                    bus.feat_valid = 1'b0;
                    @(posedge clk); #1;
                end
                if (s == go_at && w == 0) begin
                    bus.cfg_go        = 1'b1;
                    bus.cfg_n_samples = 32'd5;
                end
                bus.feat_valid = 1'b1;
                bus.feat_data  = feat_word(base + s, w);
                got = 1'b0;
                t   = 0;
                while (!got && t < 5000) begin
                    @(negedge clk);
                    got = bus.feat_ready;
                    @(posedge clk); #1;
                    t++;
                end
                bus.cfg_go = 1'b0;
                if (!got) begin
                    check("feed_timeout", 64'(got), 64'd1);
                    bus.feat_valid = 1'b0;
                    return;
                end
            end
        end
        bus.feat_valid = 1'b0;
    endtask

    task automatic consume(input int unsigned base, input int unsigned nbytes,
                           input int unsigned total, input bit stall);
        int unsigned k;
        int unsigned t;
        bit          hold_v;
        logic [7:0]  hold_data;
        logic        hold_last;
        k         = 0;
        t         = 0;
        hold_v    = 1'b0;
        hold_data = '0;
        hold_last = 1'b0;
        while (k < nbytes && t < 20000) begin
            bus.pred_ready = stall ? ($urandom_range(2) != 0) : 1'b1;
            @(negedge clk);
            if (hold_v)
                check("pred_stable", 64'({bus.pred_valid, bus.pred_last, bus.pred_data}),
                      64'({1'b1, hold_last, hold_data}));
            hold_v = 1'b0;
            if (bus.pred_valid) begin
                if (bus.pred_ready) begin
                    check("pred_data", 64'(bus.pred_data), 64'(golden(base + k)));
                    check("pred_last", 64'(bus.pred_last), 64'(k == total - 1));
                    k++;
                end else begin
                    hold_v    = 1'b1;
                    hold_data = bus.pred_data;
                    hold_last = bus.pred_last;
                end
            end
            @(posedge clk); #1;
            t++;
        end
        bus.pred_ready = 1'b0;
        check("pred_count", 64'(k), 64'(nbytes));
    endtask

    task automatic run(input int unsigned base, input int unsigned n,
                       input bit stall, input int unsigned go_at);
        int unsigned dp0;
        int unsigned nb;
        int unsigned t;
        int unsigned expl;
        dp0 = done_pulses;
        blq.delete();
        bus.cfg_n_samples = n;
        bus.cfg_go        = 1'b1;
        @(posedge clk); #1;
        bus.cfg_go = 1'b0;
        check("busy_after_go", 64'(bus.busy), 64'd1);
        fork
            feed(base, n, stall, go_at);
            consume(base, n, n, stall);
        join
        t = 0;
        while (done_pulses == dp0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("all_done_pulse", 64'(done_pulses - dp0), 64'd1);
        check("idle_after_done", 64'(bus.busy), 64'd0);
        nb = (n + MAX_BURST - 1) / MAX_BURST;
        check("burst_count", 64'(blq.size()), 64'(nb));
        for (int i = 0; i < int'(nb) && i < blq.size(); i++) begin
            expl = (i + 1 < int'(nb)) ? MAX_BURST : n - MAX_BURST * (nb - 1);
            check("burst_len", 64'(blq[i]), 64'(expl));
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned sc0;
        int unsigned rs0;
        int unsigned dp0;
        int unsigned t;

        rst               = 1'b1;
        bus.cfg_go        = 1'b0;
        bus.cfg_n_samples = '0;
        bus.feat_valid    = 1'b0;
        bus.feat_data     = '0;
        bus.pred_ready    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Empty run: done follows immediately, nothing loaded or started.
        sc0 = start_count;
        rs0 = ready_seen;
        bus.cfg_n_samples = 32'd0;
        bus.cfg_go        = 1'b1;
        @(posedge clk); #1;
        bus.cfg_go = 1'b0;
        check("zero_all_done", 64'(bus.all_done), 64'd1);
        check("zero_busy", 64'(bus.busy), 64'd1);
        @(posedge clk); #1;
        check("zero_done_cleared", 64'(bus.all_done), 64'd0);
        check("zero_idle", 64'(bus.busy), 64'd0);
        check("zero_no_start", 64'(start_count - sc0), 64'd0);
        check("zero_no_ready", 64'(ready_seen - rs0), 64'd0);

        run(100, 1, 1'b0, NONE);
        run(200, MAX_BURST, 1'b0, NONE);
        // Stalls on both streams plus a cfg_go that must be ignored mid-run.
        run(1000, 130, 1'b1, 20);

        // Reset while burst 2 is waiting on the accelerator.
        sc0 = start_count;
        dp0 = done_pulses;
        bus.cfg_n_samples = 32'd130;
        bus.cfg_go        = 1'b1;
        @(posedge clk); #1;
        bus.cfg_go = 1'b0;
        fork
            feed(3000, 2 * MAX_BURST, 1'b0, NONE);
            consume(3000, MAX_BURST, 130, 1'b0);
        join
        t = 0;
        while (start_count - sc0 < 2 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        check("second_start_seen", 64'(start_count - sc0), 64'd2);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_quiet("midrun_reset");
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("no_done_after_reset", 64'(done_pulses - dp0), 64'd0);
        check("idle_after_reset", 64'(bus.busy), 64'd0);

        run(5000, 60, 1'b1, NONE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
